lsu_data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store unit data interface. It is the slave end of the req/gnt/rvalid handshake the LSU initiates. It owns a word-addressed data RAM with byte-enable writes and returns read data or an error after a fixed, parameterised response latency. It is used as the data memory in core-level simulation, and an input lets the bench inject grant stalls.

---
 rtl/lsu_data_mem_responder.sv | 88 ++++++++
 tb/tb_lsu_data_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem_responder.sv
// Slave end of the LSU req/gnt/rvalid data interface: word-addressed RAM with
// byte-enable stores and a fixed-latency, in-order response pipeline.
module lsu_data_mem_responder #(
    parameter int unsigned              ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = ADDR_WIDTH'(32'h0000_1000),
    parameter int unsigned              DEPTH_WORDS  = 1024,
    parameter int unsigned              RESP_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic [31:0]             data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [31:0]             data_rdata_o,
    output logic                    data_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // One past the last mapped byte; one extra bit so the bound cannot overflow.
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic [31:0] r_mem  [DEPTH_WORDS];
    resp_t       r_pipe [RESP_LATENCY];

    logic             w_acc;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    resp_t            w_stage1;

    // Grant whenever requested, unless the bench stalls us or we are in reset.
    assign data_gnt_o = data_req_i & ~stall_i & rst_n;
    assign w_acc      = data_req_i & data_gnt_o;

    assign w_err = (data_addr_i < BASE_ADDR)
                 | ({1'b0, data_addr_i} >= LIMIT)
                 | (data_be_i == 4'b0000);
    assign w_idx = IDX_W'((data_addr_i - BASE_ADDR) >> 2);

    always_comb begin
        w_stage1       = '0;
        w_stage1.valid = w_acc;
        w_stage1.err   = w_acc & w_err;
        if (w_acc && !w_err && !data_we_i) begin
            w_stage1.rdata = r_mem[w_idx];
        end
    end

    // RAM is not reset; stores survive a reset of the response pipeline.
    always_ff @(posedge clk) begin
        if (w_acc && !w_err && data_we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RESP_LATENCY); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage1;
            for (int i = 1; i < int'(RESP_LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign data_rvalid_o = r_pipe[RESP_LATENCY-1].valid;
    assign data_err_o    = r_pipe[RESP_LATENCY-1].err;
    assign data_rdata_o  = r_pipe[RESP_LATENCY-1].rdata;

endmodule

// File: tb/tb_lsu_data_mem_responder.sv
// Bench for lsu_data_mem_responder: three instances (latency 1, 3, 4) share one
// stimulus stream and are checked against a cycle-indexed response history.
module tb_lsu_data_mem_responder;

    localparam int unsigned N_DUT  = 3;
    localparam int unsigned HIST_N = 4096;
    localparam int unsigned BASE   = 32'h0000_1000;
    localparam int unsigned DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        w_gnt    [N_DUT];
    logic        w_rvalid [N_DUT];
    logic [31:0] w_rdata  [N_DUT];
    logic        w_err    [N_DUT];

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_mem [DEPTH];
    bit          h_vld [HIST_N];
    bit          h_err [HIST_N];
    logic [31:0] h_rd  [HIST_N];
    int          cyc      = 0;
    int          last_rst = 0;

    always #5 clk = ~clk;

    lsu_data_mem_responder #(.RESP_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .data_req_i(req),
        .data_gnt_o(w_gnt[0]), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(w_rvalid[0]),
        .data_rdata_o(w_rdata[0]), .data_err_o(w_err[0]));

    lsu_data_mem_responder #(.RESP_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .data_req_i(req),
        .data_gnt_o(w_gnt[1]), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(w_rvalid[1]),
        .data_rdata_o(w_rdata[1]), .data_err_o(w_err[1]));

    lsu_data_mem_responder #(.RESP_LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .data_req_i(req),
        .data_gnt_o(w_gnt[2]), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(w_rvalid[2]),
        .data_rdata_o(w_rdata[2]), .data_err_o(w_err[2]));

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive, check grant, advance the model, check responses.
    task automatic step(input bit r_n, input bit rq, input bit st, input bit w,
                        input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        bit          exp_gnt;
        bit          e;
        int unsigned idx;
        logic [31:0] rd;
        int          ac;
        rst_n = r_n; req = rq; stall = st; we = w; addr = a; be = b; wdata = d;
        #3;
        exp_gnt = rq && !st && r_n;
        for (int i = 0; i < N_DUT; i++) chk($sformatf("gnt_l%0d", lat_of(i)), 32'(w_gnt[i]), 32'(exp_gnt));
        e  = (a < BASE) || (64'(a) >= 64'(BASE) + 64'(4 * DEPTH)) || (b == 4'b0000);
        rd = 32'h0;
        if (exp_gnt && !e) begin
            idx = (a - BASE) / 4;
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) m_mem[idx][8*k +: 8] = d[8*k +: 8];
            end else begin
                rd = m_mem[idx];
            end
        end
        @(posedge clk);
        cyc++;
        if (cyc >= int'(HIST_N)) begin
            $display("FAIL hist_overflow: got %0d expected below %0d", cyc, HIST_N);
            $fatal(1);
        end
        h_vld[cyc] = exp_gnt;
        h_err[cyc] = exp_gnt && e;
        h_rd[cyc]  = rd;
        if (!r_n) last_rst = cyc;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            ac = cyc - lat_of(i) + 1;
            if (ac > last_rst && h_vld[ac]) begin
                chk($sformatf("rvalid_l%0d", lat_of(i)), 32'(w_rvalid[i]), 32'd1);
                chk($sformatf("err_l%0d", lat_of(i)),    32'(w_err[i]),    32'(h_err[ac]));
                chk($sformatf("rdata_l%0d", lat_of(i)),  w_rdata[i],       h_rd[ac]);
            end else begin
                chk($sformatf("rvalid_l%0d", lat_of(i)), 32'(w_rvalid[i]), 32'd0);
                chk($sformatf("err_l%0d", lat_of(i)),    32'(w_err[i]),    32'd0);
                chk($sformatf("rdata_l%0d", lat_of(i)),  w_rdata[i],       32'd0);
            end
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Single-cycle load whose latency-1 response is also checked against a fixed value.
    task automatic ld_exp(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_rd, input bit exp_e);
        step(1'b1, 1'b1, 1'b0, 1'b0, a, 4'hF, 32'h0);
        chk({tag, "_rdata"}, w_rdata[0], exp_rd);
        chk({tag, "_err"},   32'(w_err[0]), 32'(exp_e));
    endtask

    initial begin
        bit          r_n, rq, st, w;
        logic [31:0] a, d;
        logic [3:0]  b;

        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 4'hF, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Give every word a known value before any load.
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom);

        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
        chk("st_resp_rdata", w_rdata[0], 32'h0);
        chk("st_resp_rvalid", 32'(w_rvalid[0]), 32'd1);
        ld_exp("ld_1000", 32'h1000, 32'hDEADBEEF, 1'b0);

        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1004, 4'hF, 32'h11223344);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1004, 4'b0100, 32'h00AA0000);
        ld_exp("be_merge", 32'h1006, 32'h11AA3344, 1'b0);

        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1008, 4'hF, 32'h55667788);
        ld_exp("err_low",  32'h0FFC, 32'h0, 1'b1);
        ld_exp("err_high", 32'h2000, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1008, 4'b0000, 32'hFFFFFFFF);
        chk("err_be0_err", 32'(w_err[0]), 32'd1);
        chk("err_be0_rdata", w_rdata[0], 32'h0);
        ld_exp("err_keep", 32'h1008, 32'h55667788, 1'b0);
        ld_exp("last_word_ok", 32'h1FFC, m_mem[DEPTH-1], 1'b0);

        // Four loads with the second one stalled for its first cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 4'hF, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h1004, 4'hF, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1004, 4'hF, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1008, 4'hF, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100C, 4'hF, 32'h0);
        repeat (5) idle();

        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1010, 4'hF, 32'hCAFEF00D);
        ld_exp("st_ld_fwd", 32'h1010, 32'hCAFEF00D, 1'b0);
        repeat (4) idle();

        // Reset while two loads are still in flight in the deeper pipelines.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 4'hF, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1004, 4'hF, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1008, 4'hF, 32'h0);
        repeat (6) idle();
        ld_exp("post_rst", 32'h1004, 32'h11AA3344, 1'b0);
        repeat (4) idle();

        // Random traffic; an ungranted request holds its payload.
        rq = 1'b0; w = 1'b0; a = 32'h0; b = 4'h0; d = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!(rq && (st || !r_n))) begin
                rq = ($urandom_range(0, 3) != 0);
                w  = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: a = BASE + $urandom_range(0, 63);
                    6:                a = BASE + $urandom_range(0, 4095);
                    7:                a = BASE - 32'(16) + $urandom_range(0, 15);
                    8:                a = BASE + 32'(4 * DEPTH) - 32'(8) + $urandom_range(0, 15);
                    default:          a = $urandom;
                endcase
                b = 4'($urandom_range(0, 15));
                d = $urandom;
            end
            st  = ($urandom_range(0, 4) == 0);
            r_n = ($urandom_range(0, 49) != 0);
            step(r_n, rq, st, w, a, b, d);
        end
        repeat (5) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
